sr_cmd_gen: RTL
===============

Name: sr_cmd_gen

Overview:
- Front-end command stage that drives the S/R inputs of the downstream SR flip-flop from two raw, asynchronous, bouncy request lines (set_raw, clr_raw).
- Synchronises and debounces each line, then converts debounced rising edges into single-cycle S or R pulses.
- Resolves simultaneous requests, enforces a minimum gap between pulses and keeps a shadow copy of the flip-flop state.
- Guarantees the downstream {S,R}=2'b11 invalid code is never produced.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles needed to accept a level change (>=1).
- MIN_GAP, 3: idle cycles forced after each issued pulse (>=0).
- PRIORITY, 0: simultaneous-pending winner; 0 = reset wins, 1 = set wins.
- DROP_LOSER, 0: 1 = discard the losing request on conflict; 0 = keep it pending.
- SUPPRESS_REDUNDANT, 1: 1 = drop commands that would not change q_shadow.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- set_raw  in  1  asynchronous set request
- clr_raw  in  1  asynchronous clear request
- s_out  out  1  one-cycle set pulse to the downstream S input
- r_out  out  1  one-cycle reset pulse to the downstream R input
- busy  out  1  high while in the GAP state
- conflict  out  1  one-cycle pulse when both requests are pending in IDLE
- q_shadow  out  1  model of the downstream Q

Behaviour:
- Reset is synchronous and active-high on rst, clock clk. All registers clear to 0 (synchronisers, debounce state/counters, pending bits, FSM→IDLE, gap counter, s_out, r_out, busy, conflict, q_shadow). Reset mid-operation discards all pending work.
- Synchronisation: per channel, a 2-FF synchroniser; sync2 is the usable value.
- Debounce, per channel:
  - Holds a stable bit db and a counter cnt.
  - sync2==db: cnt<=0.
  - sync2!=db and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - sync2!=db and cnt==DEBOUNCE_CYCLES-1: db<=sync2, cnt<=0.
  - Any glitch back to db restarts the count.
- Edge detection: request = db & ~db_d, where db_d is db delayed one cycle. A request sets pend_set or pend_clr at the next edge. Setting an already-set pending bit has no extra effect. Falling edges are ignored.
- FSM states: IDLE and GAP.
- IDLE, no pending: outputs 0.
- IDLE, exactly one pending:
  - If SUPPRESS_REDUNDANT=1 and the command matches q_shadow (set with q_shadow=1, or clr with q_shadow=0): clear that pending bit, no pulse, stay IDLE.
  - Otherwise: register s_out or r_out high for exactly one cycle, clear the pending bit, update q_shadow in the same edge, then go to GAP (MIN_GAP>0) or stay in IDLE (MIN_GAP=0).
- IDLE, both pending:
  - conflict pulses for 1 cycle.
  - The winner follows PRIORITY and is issued as above.
  - DROP_LOSER=1: loser cleared in the same edge.
  - DROP_LOSER=0: loser stays pending and is evaluated after the gap; redundancy is checked against the updated q_shadow.
- GAP: busy=1. gap_cnt counts MIN_GAP cycles, then returns to IDLE. New requests still latch into the pending bits during GAP.
- Invariant: s_out and r_out are never high in the same cycle, and never high in consecutive cycles when MIN_GAP>0.
- Latency: number the first clk edge that samples set_raw high (held stable) as edge 1. Then db rises at edge DEBOUNCE_CYCLES+2, pend_set at edge +3, and s_out is high in the cycle after edge DEBOUNCE_CYCLES+4. With the defaults (DEBOUNCE_CYCLES=4), s_out is high after edge 8.
- q_shadow: set by s_out, cleared by r_out. It equals the downstream Q provided both blocks share clk/rst.

Test Plan:
- Defaults, reset, set_raw held high from edge 1 → s_out high only after edge 8, q_shadow=1 after edge 8, busy high for the next 3 cycles, r_out stays 0 throughout.
- set_raw high 3 cycles, low 1, then high 4+ (D=4) → no pulse from the first burst; exactly one s_out, timed from the start of the second burst.
- set_raw and clr_raw rise on the same edge, q_shadow=0, PRIORITY=0, DROP_LOSER=0, SUPPRESS_REDUNDANT=0 → conflict pulse; r_out first; s_out exactly MIN_GAP+1 cycles later; q_shadow ends 1.
- Same as above with PRIORITY=1, DROP_LOSER=1 → single s_out, no r_out, q_shadow=1.
- q_shadow=1, then a second debounced set_raw rise with SUPPRESS_REDUNDANT=1 → no s_out, busy stays 0, pend_set clears.
- rst asserted while in GAP with clr pending → all outputs 0 the next cycle, no r_out after rst deasserts, q_shadow=0.

Source files
------------

// File: rtl/sr_cmd_gen.sv
// rtl/sr_cmd_gen.sv - S/R command generator for a downstream SR flip-flop
//
// Turns two raw, asynchronous, bouncy request lines into clean single-cycle
// S or R pulses. Each line is synchronised (2 FF), debounced and edge
// detected; rising edges latch into pending bits that a small IDLE/GAP FSM
// arbitrates, spaces out and optionally filters against a shadow of Q.
// s_out and r_out are never high together.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous reset, active-high
//   set_raw   in   asynchronous set request
//   clr_raw   in   asynchronous clear request
//   s_out     out  one-cycle set pulse to the downstream S input
//   r_out     out  one-cycle reset pulse to the downstream R input
//   busy      out  high while in the GAP state
//   conflict  out  one-cycle pulse when both requests are pending in IDLE
//   q_shadow  out  model of the downstream Q

module sr_cmd_gen #(
    parameter int DEBOUNCE_CYCLES    = 4,
    parameter int MIN_GAP            = 3,
    parameter int PRIORITY           = 0,
    parameter int DROP_LOSER         = 0,
    parameter int SUPPRESS_REDUNDANT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_raw,
    input  logic clr_raw,
    output logic s_out,
    output logic r_out,
    output logic busy,
    output logic conflict,
    output logic q_shadow
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    // Channel index 0 = set request, 1 = clear request.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db;
    logic [1:0]    db_d;
    logic [CW-1:0] cnt [2];
    logic [1:0]    rise;

    logic [1:0]    pend;
    logic [1:0]    pend_clear;
    logic [1:0]    pend_next;

    state_t        state;
    state_t        state_next;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_cnt_next;

    logic          s_next;
    logic          r_next;
    logic          conflict_next;
    logic          q_next;
    logic          win_set;
    logic          redundant;

    assign raw  = {clr_raw, set_raw};
    assign rise = db & ~db_d;

    // Synchroniser, debounce and edge-detect delay for both channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            db    <= 2'b00;
            db_d  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_d  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A fresh edge in the same cycle as a clear must survive, so OR it last.
    assign pend_next = (pend & ~pend_clear) | rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            pend     <= 2'b00;
            s_out    <= 1'b0;
            r_out    <= 1'b0;
            conflict <= 1'b0;
            q_shadow <= 1'b0;
        end else begin
            state    <= state_next;
            gap_cnt  <= gap_cnt_next;
            pend     <= pend_next;
            s_out    <= s_next;
            r_out    <= r_next;
            conflict <= conflict_next;
            q_shadow <= q_next;
        end
    end

    always_comb begin
        state_next    = state;
        gap_cnt_next  = gap_cnt;
        pend_clear    = 2'b00;
        s_next        = 1'b0;
        r_next        = 1'b0;
        conflict_next = 1'b0;
        q_next        = q_shadow;
        win_set       = 1'b0;
        redundant     = 1'b0;

        case (state)
            IDLE: begin
                if (pend != 2'b00) begin
                    if (pend == 2'b11) begin
                        conflict_next = 1'b1;
                        win_set       = (PRIORITY != 0);
                        if (DROP_LOSER != 0) begin
                            pend_clear = 2'b11;
                        end else begin
                            pend_clear = win_set ? 2'b01 : 2'b10;
                        end
                    end else begin
                        win_set    = pend[0];
                        pend_clear = pend;
                    end

                    // A command that would not move Q is consumed silently.
                    redundant = (SUPPRESS_REDUNDANT != 0) && (win_set == q_shadow);

                    if (!redundant) begin
                        s_next = win_set;
                        r_next = ~win_set;
                        q_next = win_set;
                        if (MIN_GAP > 0) begin
                            state_next   = GAP;
                            gap_cnt_next = '0;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next   = IDLE;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                gap_cnt_next = '0;
            end
        endcase
    end

    assign busy = (state == GAP);

endmodule
